// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_detect_pkg : shared constants, types and 7-segment table for seq_detect_n
// Revision: 1.0
// ---------------------------------------------------------------------------
package seq_detect_pkg;

  localparam int unsigned c_prog_w    = 3;
  localparam int unsigned c_pat_w_min = 2;
  localparam int unsigned c_pat_w_max = 8;

  typedef logic [c_prog_w-1:0] prog_t;
  typedef logic [6:0]          seg_t;

  // {a..g}, active-low; index is the progress value
  localparam seg_t [7:0] c_seg_tab = {
    7'b0001111,
    7'b0100000,
    7'b0100100,
    7'b1001100,
    7'b0000110,
    7'b0010010,
    7'b1001111,
    7'b0000001
  };

  function automatic seg_t seg_lut(input prog_t prog);
    return c_seg_tab[prog];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tick_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_tick_div : one-clk tick every DIV clocks, restarted by clr
// Revision: 1.0
// ---------------------------------------------------------------------------
module seq_tick_div #(
  parameter int unsigned DIV = 20000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned        c_cnt_w = $clog2(DIV);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               w_wrap;

  always_comb begin
    w_wrap = (cnt_q == c_last);
    cnt_d  = w_wrap ? '0 : cnt_q + c_cnt_w'(1);
    tick_d = w_wrap;
    if (clr) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/seq_detect_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_detect_n : ticked serial pattern detector with prefix/suffix fallback
// Optional match counter: define SEQ_DETECT_CNT_EN.   Revision: 1.0
// ---------------------------------------------------------------------------
module seq_detect_n
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned DIV   = 20000000,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                x,
  input  logic [PAT_W-1:0]    pattern,
  input  logic                overlap_en,
  input  logic                clr,
  output logic                tick,
  output logic                y,
  output logic [c_prog_w-1:0] progress,
  output logic [6:0]          seg,
  output logic [CNT_W-1:0]    match_cnt
);

  if (PAT_W < c_pat_w_min || PAT_W > c_pat_w_max || DIV < 2) begin : g_bad_param
    $error("seq_detect_n: PAT_W or DIV out of range");
  end

  localparam logic [PAT_W-1:0] c_ones      = '1;
  localparam prog_t            c_prog_last = c_prog_w'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic             pat_vld_q, pat_vld_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  prog_t            prog_q, prog_d;
  logic             y_q, y_d;
  seg_t             seg_q, seg_d;

  logic [PAT_W-1:0] w_win;
  logic             w_hit;
  logic             w_full;
  prog_t            w_best;

  seq_tick_div #(
    .DIV (DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  // Longest pattern prefix that ends the sample stream, bounded by k+1.
  // On a full match the best proper prefix is exactly the pattern border.
  always_comb begin
    w_win  = {hist_q, x};
    w_hit  = 1'b0;
    w_full = 1'b0;
    w_best = '0;
    for (int j = 1; j <= int'(PAT_W); j++) begin
      w_hit = ((pat_q >> (PAT_W - j)) == (w_win & (c_ones >> (PAT_W - j))));
      if (j == int'(PAT_W)) begin
        w_full = w_hit && (prog_q == c_prog_last);
      end else if (w_hit && (j <= int'(prog_q) + 1)) begin
        w_best = c_prog_w'(j);
      end
    end
  end

  always_comb begin
    pat_d     = pat_q;
    pat_vld_d = 1'b1;
    hist_d    = hist_q;
    prog_d    = prog_q;
    y_d       = 1'b0;
    if (clr || !pat_vld_q) begin
      pat_d = pattern;
    end
    if (clr) begin
      hist_d = '0;
      prog_d = '0;
    end else if (tick) begin
      hist_d = w_win[PAT_W-2:0];
      prog_d = w_best;
      if (w_full) begin
        y_d = 1'b1;
        if (!overlap_en) begin
          hist_d = '0;
          prog_d = '0;
        end
      end
    end
    seg_d = seg_lut(prog_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q     <= '0;
      pat_vld_q <= 1'b0;
      hist_q    <= '0;
      prog_q    <= '0;
      y_q       <= 1'b0;
      seg_q     <= 7'b0000001;
    end else begin
      pat_q     <= pat_d;
      pat_vld_q <= pat_vld_d;
      hist_q    <= hist_d;
      prog_q    <= prog_d;
      y_q       <= y_d;
      seg_q     <= seg_d;
    end
  end

  assign y        = y_q;
  assign progress = prog_q;
  assign seg      = seg_q;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (y_d && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_detect_n : directed vector bench for seq_detect_n (PAT_W=4, DIV=4)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_seq_detect_n;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned DIV   = 4;
`ifdef SEQ_DETECT_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic             x          = 1'b0;
  logic             overlap_en = 1'b1;
  logic             clr        = 1'b0;
  logic [PAT_W-1:0] pattern    = 4'b0101;

  logic       tick_a, y_a, tick_b, y_b;
  logic [2:0] progress_a, progress_b;
  logic [6:0] seg_a, seg_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  seq_detect_n #(.PAT_W(PAT_W), .DIV(DIV), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .x(x), .pattern(pattern), .overlap_en(overlap_en),
    .clr(clr), .tick(tick_a), .y(y_a), .progress(progress_a), .seg(seg_a),
    .match_cnt(cnt_a)
  );

  seq_detect_n #(.PAT_W(PAT_W), .DIV(DIV), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .x(x), .pattern(pattern), .overlap_en(overlap_en),
    .clr(clr), .tick(tick_b), .y(y_b), .progress(progress_b), .seg(seg_b),
    .match_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  int errors    = 0;
  int checks    = 0;
  int cnt_model = 0;

  logic [6:0] seg_ref [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};

  typedef struct {
    bit clr_first;
    bit ovl;
    bit xb;
    bit ey;
    int ep;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tick"}, int'(tick_a), 0);
    chk({tag, "_y"}, int'(y_a), 0);
    chk({tag, "_prog"}, int'(progress_a), 0);
    chk({tag, "_seg"}, int'(seg_a), int'(7'b0000001));
    chk({tag, "_cnt"}, int'(cnt_a), 0);
    chk({tag, "_tick_sat"}, int'(tick_b), 0);
    chk({tag, "_y_sat"}, int'(y_b), 0);
    chk({tag, "_prog_sat"}, int'(progress_b), 0);
    chk({tag, "_seg_sat"}, int'(seg_b), int'(7'b0000001));
    chk({tag, "_cnt_sat"}, int'(cnt_b), 0);
  endtask

  task automatic chk_out(input string tag, input bit ey, input int ep);
    chk({tag, "_y"}, int'(y_a), int'(ey));
    chk({tag, "_prog"}, int'(progress_a), ep);
    chk({tag, "_seg"}, int'(seg_a), int'(seg_ref[ep]));
    chk({tag, "_cnt"}, int'(cnt_a), CNT_ON * cnt_model);
    chk({tag, "_y_sat"}, int'(y_b), int'(ey));
    chk({tag, "_prog_sat"}, int'(progress_b), ep);
    chk({tag, "_cnt_sat"}, int'(cnt_b), CNT_ON * ((cnt_model > 3) ? 3 : cnt_model));
  endtask

  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < int'(3 * DIV) && !seen; i++) begin
      @(negedge clk);
      if (tick_a === 1'b1) seen = 1'b1;
    end
    chk({tag, "_tick_seen"}, int'(seen), 1);
  endtask

  task automatic send_bit(input bit b, input bit ey, input int ep, input string tag);
    x = b;
    wait_tick(tag);
    @(posedge clk);
    #1;
    if (ey) cnt_model++;
    chk_out(tag, ey, ep);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cnt_model = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;

    // overlapping 0101 stream, then non-overlapping, then fallback cases
    vecs.push_back('{1, 1, 0, 0, 1}); vecs.push_back('{0, 1, 1, 0, 2});
    vecs.push_back('{0, 1, 0, 0, 3}); vecs.push_back('{0, 1, 1, 1, 2});
    vecs.push_back('{0, 1, 0, 0, 3}); vecs.push_back('{0, 1, 1, 1, 2});
    vecs.push_back('{1, 0, 0, 0, 1}); vecs.push_back('{0, 0, 1, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 3}); vecs.push_back('{0, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 1}); vecs.push_back('{0, 0, 1, 0, 2});
    vecs.push_back('{1, 1, 0, 0, 1}); vecs.push_back('{0, 1, 0, 0, 1});
    vecs.push_back('{1, 1, 0, 0, 1}); vecs.push_back('{0, 1, 1, 0, 2});
    vecs.push_back('{0, 1, 1, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 1}); vecs.push_back('{0, 1, 1, 0, 2});
    vecs.push_back('{0, 1, 0, 0, 3}); vecs.push_back('{0, 1, 0, 0, 1});

    repeat (3) @(negedge clk);
    chk_reset("rst");

    rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= int'(3 * DIV) && first < 0; i++) begin
      @(posedge clk);
      #1;
      if (tick_a) first = i;
    end
    chk("first_tick_delay", first, int'(DIV));

    foreach (vecs[i]) begin
      if (vecs[i].clr_first) do_clr();
      overlap_en = vecs[i].ovl;
      send_bit(vecs[i].xb, vecs[i].ey, vecs[i].ep, $sformatf("vec%0d", i));
    end

    // pattern input ignored without clr; clr colliding with the completing tick
    do_clr();
    overlap_en = 1'b1;
    pattern = 4'b1111;
    send_bit(1'b0, 1'b0, 1, "ign0");
    send_bit(1'b1, 1'b0, 2, "ign1");
    send_bit(1'b0, 1'b0, 3, "ign2");
    x = 1'b1;
    wait_tick("clrtick");
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    cnt_model = 0;
    chk("clrtick_tick", int'(tick_a), 0);
    chk_out("clrtick", 1'b0, 0);
    first = -1;
    for (int i = 1; i <= int'(2 * DIV) && first < 0; i++) begin
      @(posedge clk);
      #1;
      if (tick_a) first = i;
    end
    chk("clr_tick_delay", first, int'(DIV));
    @(posedge clk);
    #1;
    chk_out("newpat0", 1'b0, 1);
    send_bit(1'b1, 1'b0, 2, "newpat1");
    send_bit(1'b1, 1'b0, 3, "newpat2");
    send_bit(1'b1, 1'b1, 3, "newpat3");

    // five overlapping matches: narrow counter saturates
    pattern = 4'b0101;
    do_clr();
    for (int n = 0; n < 12; n++) begin
      if (n < 3)
        send_bit(n[0], 1'b0, n + 1, $sformatf("sat%0d", n));
      else if (n[0])
        send_bit(1'b1, 1'b1, 2, $sformatf("sat%0d", n));
      else
        send_bit(1'b0, 1'b0, 3, $sformatf("sat%0d", n));
    end

    // asynchronous reset in the middle of a partial match
    send_bit(1'b0, 1'b0, 3, "pre_rst");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    cnt_model = 0;
    chk_reset("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b0, 1'b0, 1, "post_rst0");
    send_bit(1'b1, 1'b0, 2, "post_rst1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_detect_n.md
SEQ_DETECT_N -- requirements
Module: seq_detect_n

Interface
REQ-001 SHALL have parameter PAT_W, default 4, meaning pattern length in bits (legal range 2..8).
REQ-002 SHALL have parameter DIV, default 20000000, meaning clk cycles per sample tick (legal range 2 upward).
REQ-003 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-004 SHALL have port clk  input  1  system clock, sole clock of the block.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port x  input  1  serial data bit, sampled only on tick.
REQ-007 SHALL have port pattern  input  PAT_W  target sequence; pattern[PAT_W-1] is the first bit expected.
REQ-008 SHALL have port overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port clr  input  1  synchronous restart; it also relatches pattern.
REQ-010 SHALL have port tick  output  1  one-clk pulse per sample instant.
REQ-011 SHALL have port y  output  1  one-clk match pulse.
REQ-012 SHALL have port progress  output  3  number of pattern bits currently matched (0..PAT_W-1).
REQ-013 SHALL have port seg  output  7  {a..g} active-low 7-segment code of progress.
REQ-014 SHALL have port match_cnt  output  CNT_W  count of matches.

Function
REQ-015 The divider SHALL assert tick for exactly one clk cycle every DIV clk cycles, with the first tick occurring DIV cycles after reset release or clr.
REQ-016 x SHALL be sampled only in the clk cycle where tick=1, and all other cycles SHALL leave progress unchanged.
REQ-017 The pattern register SHALL load from pattern on reset release and on clr, and changes to pattern at any other time SHALL be ignored.
REQ-018 On a tick with progress=k, next progress SHALL be the largest j ≤ k+1 such that the first j pattern bits equal the last j sampled bits (prefix/suffix fallback, not a blind return to 0).
REQ-019 When j reaches PAT_W, y SHALL pulse high for the clk cycle after the tick.
REQ-020 After a match with overlap_en=1, progress SHALL become the longest proper prefix of the pattern that is also a suffix of it.
REQ-021 After a match with overlap_en=0, progress SHALL become 0 and sample history SHALL clear.
REQ-022 progress SHALL be registered, update one clk after the tick, and never equal PAT_W.
REQ-023 seg SHALL be registered and follow progress with the same latency, using these codes:
  - 0 → 0000001
  - 1 → 1001111
  - 2 → 0010010
  - 3 → 0000110
  - 4 → 1001100
  - 5 → 0100100
  - 6 → 0100000
  - 7 → 0001111
REQ-024 match_cnt SHALL increment on each y pulse and saturate at all-ones.
REQ-025 When clr and tick occur in the same cycle, clr SHALL win: x is discarded, progress=0, history is cleared, match_cnt=0, and the divider restarts.
REQ-026 A change of overlap_en SHALL take effect from the next tick.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force:
  - progress=0, history=0, y=0, tick=0
  - divider=0, match_cnt=0
  - seg=0000001
REQ-028 Reset asserted mid-sequence SHALL abandon partial progress, with no y pulse.

Configuration
REQ-029 With macro SEQ_DETECT_CNT_EN defined, match_cnt SHALL be implemented per REQ-024.
REQ-030 Without SEQ_DETECT_CNT_EN, match_cnt SHALL be tied to 0, no counter flops SHALL be synthesised, and all other behaviour SHALL be unchanged.

Structure
REQ-031 Package seq_detect_pkg SHALL hold:
  - the 7-segment code table and its lookup function
  - the progress width constant (3)
  - the PAT_W legal-range limits
REQ-032 Sub-module seq_tick_div SHALL implement the DIV divider and tick.
REQ-033 The detector FSM and the fallback search SHALL live in seq_detect_n.

Verification
REQ-034 With PAT_W=4, pattern=0101, DIV=4, overlap_en=1 and x=0,1,0,1,0,1 on ticks → y pulses after tick 4 and tick 6, match_cnt=2, and final progress=2 with seg=0010010.
REQ-035 The same stream with overlap_en=0 → a single y pulse after tick 4, progress=2 after tick 6, match_cnt=1.
REQ-036 Mismatch fallback with pattern=0101: x=0,0 → progress=1; x=0,1,1 → progress=0; x=0,1,0,0 → progress=1.
REQ-037 rst_n driven low at progress=3 → all outputs reach reset values immediately, and the following 0,1 stream gives progress=2 with no spurious y.
REQ-038 clr asserted on the same cycle as a tick that would complete 0101 → no y, match_cnt=0, the next tick occurs 4 clk cycles later, and the new pattern value is latched.
REQ-039 With CNT_W=2, 5 matches → match_cnt=3 (saturated); without SEQ_DETECT_CNT_EN, match_cnt=0 throughout.
